xdma_dsc_byp_arbiter: RTL and testbench
=======================================

# xdma_dsc_byp_arbiter

Parametrised N-channel arbiter that lets several user-logic requesters share one XDMA descriptor-bypass port (H2C or C2H; one instance per direction). It sits between the BSV user logic and the `xdma_0` `*_dsc_byp_*` / `*_sts_0[3]` signals, in the `user_clk` domain. It grants requests round-robin, presents one descriptor at a time to XDMA, and records the owning channel of every issued descriptor. It routes each XDMA descriptor-done pulse back to the channel that issued that descriptor, in issue order.

## Interface
Parameters:
- `NUM_CH`, 4, number of requester channels (2..16)
- `MAX_OUTSTANDING`, 8, depth of the issued-descriptor tag FIFO (power of 2, ≥2)
- `ADDR_WIDTH`, 64, src/dst address width
- `LEN_WIDTH`, 28, length width

Ports:
- `CLK`  in  1  `user_clk` domain clock
- `RST`  in  1  asynchronous, active-high reset
- `req_valid`  in  NUM_CH  per-channel descriptor valid
- `req_ready`  out  NUM_CH  per-channel accept (one-hot or zero)
- `req_src_addr`  in  NUM_CH*ADDR_WIDTH  packed; channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- `req_dst_addr`  in  NUM_CH*ADDR_WIDTH  packed, same layout
- `req_len`  in  NUM_CH*LEN_WIDTH  packed
- `req_ctl`  in  NUM_CH*16  packed
- `done`  out  NUM_CH  one-cycle completion pulse per channel
- `byp_load`  out  1  to `*_dsc_byp_load_0`
- `byp_ready`  in  1  from `*_dsc_byp_ready_0`
- `byp_src_addr`  out  ADDR_WIDTH  descriptor source address
- `byp_dst_addr`  out  ADDR_WIDTH  descriptor destination address
- `byp_len`  out  LEN_WIDTH  descriptor length
- `byp_ctl`  out  16  descriptor control
- `byp_desc_done`  in  1  from `*_sts_0[3]`; one pulse per completed descriptor
- `outstanding`  out  $clog2(MAX_OUTSTANDING)+1  number of issued, not-yet-done descriptors
- `err_spurious_done`  out  1  sticky; set on `byp_desc_done` while `outstanding`==0

## Operation
- FSM has two states: IDLE and LOAD.
- IDLE:
  - If any `req_valid` is high and the tag FIFO is not full, select winner w by round-robin, searching from `rr_ptr` upward with wrap.
  - Assert `req_ready[w]` combinationally in that cycle.
  - Latch channel w's src/dst/len/ctl into the output registers and w into `cur_ch`.
  - Set `rr_ptr` to (w+1) mod NUM_CH and go to LOAD.
  - If the FIFO is full, assert no `req_ready` and stay in IDLE.
- LOAD:
  - `byp_load` is held high and the `byp_*` fields are held stable.
  - On `byp_load && byp_ready`, push `cur_ch` into the tag FIFO, drop `byp_load`, and return to IDLE.
- Completion:
  - On `byp_desc_done` with the FIFO non-empty, pop the head channel c and pulse `done[c]` on the next cycle.
  - On `byp_desc_done` with the FIFO empty, set `err_spurious_done`, pop nothing and pulse no `done`.
- A push and a pop in the same cycle are both performed; `outstanding` is unchanged in that case.
- `outstanding` = pushes − pops. It never exceeds MAX_OUTSTANDING and never underflows.
- Request fields are treated as opaque; `len`==0 is forwarded unchanged.
- Reset (asserted at any time, including mid-LOAD):
  - Immediately: `byp_load`=0, `req_ready`=0, `done`=0, `byp_*` fields=0.
  - FSM=IDLE, `rr_ptr`=0, FIFO empty, `outstanding`=0, `err_spurious_done`=0.
  - Tags of in-flight descriptors are discarded, and no `done` is produced for them.

## Timing
- From a `req_valid` seen in IDLE to `byp_load` high: 1 cycle (the grant cycle, then LOAD).
- Peak throughput is one descriptor per 2 cycles while `byp_ready` stays high.
- From `byp_desc_done` at cycle t to `done[c]` at cycle t+1. `done` is registered, at most one bit high, and exactly 1 cycle wide.
- `req_ready` depends combinationally on `req_valid`, FSM state and FIFO-full only; it never depends on `byp_ready`.
- `byp_load` and the `byp_*` fields come straight from registers; there is no combinational path from any input.
- `outstanding` updates 1 cycle after a push or pop event.

## Configuration
- `XDMA_DSC_ARB_STATS_EN` defined:
  - Adds output `stat_issued` (NUM_CH*32, packed per channel).
  - Each counter increments on every `byp_load && byp_ready` for its channel and saturates at 0xFFFF_FFFF.
  - Counters are cleared by `RST`.
- Macro not defined: the port and the counters are absent, and all other behaviour is identical.

## Test plan
- NUM_CH=4, all four `req_valid` held high, `byp_ready`=1 → grants in order 0,1,2,3,0; `byp_load` high every other cycle.
- Channel 2 alone issues one descriptor (src=0x1000, dst=0x2000, len=64, ctl=0x0013), `byp_ready` held low for 5 cycles → `byp_load` and fields stay stable for 5 cycles; handshake on cycle 6; `outstanding`=1.
- MAX_OUTSTANDING=8, 8 descriptors issued with no `byp_desc_done` → 9th request gets no `req_ready`; after one `byp_desc_done`, it is granted on the following IDLE cycle.
- Issue order ch 1,3,1 then three `byp_desc_done` pulses → `done[1]`, `done[3]`, `done[1]`, each 1 cycle after its pulse; `outstanding` returns to 0.
- `byp_desc_done` with `outstanding`=0 → `err_spurious_done`=1 (sticky), no `done` pulse; `RST` pulse mid-LOAD with `outstanding`=3 → `byp_load` and `outstanding` drop to 0 immediately, and subsequent `byp_desc_done` sets the error.

Source files
------------

// File: rtl/xdma_dsc_byp_arbiter.sv
// rtl/xdma_dsc_byp_arbiter.sv - round-robin N-channel arbiter for one XDMA descriptor-bypass port
//
// Optional feature macro: XDMA_DSC_ARB_STATS_EN (adds per-channel issued counters on stat_issued)
//
// Ports:
//   CLK, RST                      user_clk domain clock, asynchronous active-high reset
//   req_valid/req_ready           per-channel descriptor handshake (ready is one-hot or zero)
//   req_src_addr/req_dst_addr     packed per-channel addresses, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_len/req_ctl               packed per-channel length and control
//   done                          one-cycle completion pulse to the channel that issued the descriptor
//   byp_load/byp_ready            descriptor handshake towards XDMA
//   byp_src_addr..byp_ctl         registered descriptor fields
//   byp_desc_done                 XDMA descriptor-complete pulse
//   outstanding                   issued, not-yet-completed descriptors
//   err_spurious_done             sticky: completion seen with nothing outstanding
//   stat_issued                   (XDMA_DSC_ARB_STATS_EN only) packed 32-bit saturating counters
module xdma_dsc_byp_arbiter #(
    parameter int NUM_CH          = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int ADDR_WIDTH      = 64,
    parameter int LEN_WIDTH       = 28
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic [NUM_CH-1:0]                   req_valid,
    output logic [NUM_CH-1:0]                   req_ready,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]        req_src_addr,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]        req_dst_addr,
    input  logic [NUM_CH*LEN_WIDTH-1:0]         req_len,
    input  logic [NUM_CH*16-1:0]                req_ctl,
    output logic [NUM_CH-1:0]                   done,
    output logic                                byp_load,
    input  logic                                byp_ready,
    output logic [ADDR_WIDTH-1:0]               byp_src_addr,
    output logic [ADDR_WIDTH-1:0]               byp_dst_addr,
    output logic [LEN_WIDTH-1:0]                byp_len,
    output logic [15:0]                         byp_ctl,
    input  logic                                byp_desc_done,
    output logic [$clog2(MAX_OUTSTANDING):0]    outstanding,
    output logic                                err_spurious_done
`ifdef XDMA_DSC_ARB_STATS_EN
    ,
    output logic [NUM_CH*32-1:0]                stat_issued
`endif
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam int AW   = $clog2(MAX_OUTSTANDING);
    localparam int OW   = AW + 1;

    typedef enum logic {IDLE, LOAD} state_t;

    state_t          state;
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] cur_ch;
    logic [CH_W-1:0] grant_ch;
    logic            grant_any;
    logic            grant;
    logic            full;
    logic            push;
    logic            pop;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CH_W-1:0] tag_mem [MAX_OUTSTANDING];

    // First requester at or after rr_ptr, wrapping past the last channel.
    always_comb begin
        int idx;
        grant_any = 1'b0;
        grant_ch  = '0;
        idx       = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!grant_any && req_valid[CH_W'(idx)]) begin
                grant_any = 1'b1;
                grant_ch  = CH_W'(idx);
            end
        end
    end

    assign full  = (outstanding == OW'(MAX_OUTSTANDING));
    assign grant = (state == IDLE) && !full && grant_any;
    // RST gates the grant so no channel sees an accept while reset is held.
    assign req_ready = (grant && !RST) ? (NUM_CH'(1) << grant_ch) : '0;
    assign push  = byp_load && byp_ready;
    assign pop   = byp_desc_done && (outstanding != '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state             <= IDLE;
            byp_load          <= 1'b0;
            byp_src_addr      <= '0;
            byp_dst_addr      <= '0;
            byp_len           <= '0;
            byp_ctl           <= '0;
            cur_ch            <= '0;
            rr_ptr            <= '0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            outstanding       <= '0;
            err_spurious_done <= 1'b0;
            done              <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        byp_src_addr <= req_src_addr[grant_ch*ADDR_WIDTH +: ADDR_WIDTH];
                        byp_dst_addr <= req_dst_addr[grant_ch*ADDR_WIDTH +: ADDR_WIDTH];
                        byp_len      <= req_len[grant_ch*LEN_WIDTH +: LEN_WIDTH];
                        byp_ctl      <= req_ctl[grant_ch*16 +: 16];
                        cur_ch       <= grant_ch;
                        rr_ptr       <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);
                        byp_load     <= 1'b1;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    if (push) begin
                        byp_load <= 1'b0;
                        wr_ptr   <= wr_ptr + AW'(1);
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (pop) begin
                rd_ptr               <= rd_ptr + AW'(1);
                done[tag_mem[rd_ptr]] <= 1'b1;
            end
            if (byp_desc_done && (outstanding == '0))
                err_spurious_done <= 1'b1;

            // Simultaneous push and pop leave the count unchanged.
            case ({push, pop})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Tag storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge CLK) begin
        if (push) tag_mem[wr_ptr] <= cur_ch;
    end

`ifdef XDMA_DSC_ARB_STATS_EN
    logic [31:0] stat_cnt [NUM_CH];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_CH; i++) stat_cnt[i] <= '0;
        end else if (push && (stat_cnt[cur_ch] != 32'hFFFF_FFFF)) begin
            stat_cnt[cur_ch] <= stat_cnt[cur_ch] + 32'd1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_stat
        assign stat_issued[g*32 +: 32] = stat_cnt[g];
    end
`endif

endmodule

// File: tb/tb_xdma_dsc_byp_arbiter.sv
// tb/tb_xdma_dsc_byp_arbiter.sv - scoreboard bench for xdma_dsc_byp_arbiter
module tb_xdma_dsc_byp_arbiter;

    localparam int NUM_CH = 4;
    localparam int MAXO   = 8;
    localparam int AWD    = 64;
    localparam int LW     = 28;
    localparam int OW     = 4;

    logic                    CLK = 1'b0;
    logic                    RST;
    logic [NUM_CH-1:0]       req_valid;
    logic [NUM_CH-1:0]       req_ready;
    logic [NUM_CH*AWD-1:0]   req_src_addr;
    logic [NUM_CH*AWD-1:0]   req_dst_addr;
    logic [NUM_CH*LW-1:0]    req_len;
    logic [NUM_CH*16-1:0]    req_ctl;
    logic [NUM_CH-1:0]       done;
    logic                    byp_load;
    logic                    byp_ready;
    logic [AWD-1:0]          byp_src_addr;
    logic [AWD-1:0]          byp_dst_addr;
    logic [LW-1:0]           byp_len;
    logic [15:0]             byp_ctl;
    logic                    byp_desc_done;
    logic [OW-1:0]           outstanding;
    logic                    err_spurious_done;

    always #5 CLK = ~CLK;

    xdma_dsc_byp_arbiter #(
        .NUM_CH(NUM_CH), .MAX_OUTSTANDING(MAXO), .ADDR_WIDTH(AWD), .LEN_WIDTH(LW)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src_addr(req_src_addr), .req_dst_addr(req_dst_addr),
        .req_len(req_len), .req_ctl(req_ctl),
        .done(done),
        .byp_load(byp_load), .byp_ready(byp_ready),
        .byp_src_addr(byp_src_addr), .byp_dst_addr(byp_dst_addr),
        .byp_len(byp_len), .byp_ctl(byp_ctl),
        .byp_desc_done(byp_desc_done),
        .outstanding(outstanding), .err_spurious_done(err_spurious_done)
    );

    typedef struct {
        logic [AWD-1:0] src;
        logic [AWD-1:0] dst;
        logic [LW-1:0]  len;
        logic [15:0]    ctl;
    } desc_t;

    typedef struct {
        logic [NUM_CH-1:0] rdy;
        logic              load;
        logic [NUM_CH-1:0] dn;
        logic [OW-1:0]     outs;
        logic              err;
    } cyc_t;

    desc_t exp_desc[$];
    cyc_t  exp_cyc[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model: a list of issued channels in issue order, a busy flag and a next-search pointer.
    bit          m_load;
    int          m_cur;
    int          m_rr;
    int          m_tags[$];
    bit          m_err;
    logic [NUM_CH-1:0] m_done_next;

    bit          fix_fields = 1'b0;
    desc_t       fix_desc;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [NUM_CH-1:0] v, input bit rdy, input bit dd, input bit rst);
        cyc_t  e;
        desc_t d;
        int    n_before;
        int    w;
        @(posedge CLK);
        #1;
        RST           = rst;
        req_valid     = v;
        byp_ready     = rdy;
        byp_desc_done = rst ? 1'b0 : dd;
        for (int c = 0; c < NUM_CH; c++) begin
            if (fix_fields) begin
                d = fix_desc;
            end else begin
                d.src = {$urandom, $urandom};
                d.dst = {$urandom, $urandom};
                d.len = ($urandom % 8 == 0) ? '0 : LW'($urandom);
                d.ctl = 16'($urandom);
            end
            req_src_addr[c*AWD +: AWD] = d.src;
            req_dst_addr[c*AWD +: AWD] = d.dst;
            req_len[c*LW +: LW]        = d.len;
            req_ctl[c*16 +: 16]        = d.ctl;
        end
        e = '{rdy: '0, load: 1'b0, dn: '0, outs: '0, err: 1'b0};
        if (rst) begin
            m_load = 1'b0;
            m_rr = 0;
            m_tags.delete();
            m_err = 1'b0;
            m_done_next = '0;
            exp_desc.delete();
            exp_cyc.push_back(e);
            return;
        end
        e.load = m_load;
        e.outs = OW'(m_tags.size());
        e.err  = m_err;
        e.dn   = m_done_next;
        m_done_next = '0;
        n_before = m_tags.size();
        if (byp_desc_done) begin
            if (m_tags.size() == 0) m_err = 1'b1;
            else m_done_next[m_tags.pop_front()] = 1'b1;
        end
        if (m_load) begin
            if (rdy) begin
                m_tags.push_back(m_cur);
                m_load = 1'b0;
            end
        end else if (v != '0 && n_before < MAXO) begin
            w = -1;
            for (int k = 0; k < NUM_CH; k++)
                if (w < 0 && v[(m_rr + k) % NUM_CH]) w = (m_rr + k) % NUM_CH;
            e.rdy[w] = 1'b1;
            d.src = req_src_addr[w*AWD +: AWD];
            d.dst = req_dst_addr[w*AWD +: AWD];
            d.len = req_len[w*LW +: LW];
            d.ctl = req_ctl[w*16 +: 16];
            exp_desc.push_back(d);
            m_cur  = w;
            m_rr   = (w + 1) % NUM_CH;
            m_load = 1'b1;
        end
        exp_cyc.push_back(e);
    endtask

    // Monitor: per-cycle expectations plus the descriptor stream whenever byp_load is up.
    always @(negedge CLK) begin
        cyc_t  e;
        desc_t d;
        if (exp_cyc.size() > 0) begin
            e = exp_cyc.pop_front();
            chk("req_ready", 192'(req_ready), 192'(e.rdy));
            chk("byp_load", 192'(byp_load), 192'(e.load));
            chk("done", 192'(done), 192'(e.dn));
            chk("outstanding", 192'(outstanding), 192'(e.outs));
            chk("err_spurious_done", 192'(err_spurious_done), 192'(e.err));
            if (RST) begin
                chk("reset_fields", {byp_src_addr, byp_dst_addr, byp_len, byp_ctl}, '0);
            end
        end
        if (byp_load) begin
            if (exp_desc.size() == 0) begin
                chk("desc_unexpected", 192'(1), 192'(0));
            end else begin
                d = exp_desc[0];
                chk("byp_fields", {byp_src_addr, byp_dst_addr, byp_len, byp_ctl},
                    {d.src, d.dst, d.len, d.ctl});
                if (byp_ready) void'(exp_desc.pop_front());
            end
        end
    end

    initial begin
        RST = 1'b1;
        req_valid = '0;
        byp_ready = 1'b0;
        byp_desc_done = 1'b0;
        req_src_addr = '0;
        req_dst_addr = '0;
        req_len = '0;
        req_ctl = '0;

        repeat (3) step('0, 1'b0, 1'b0, 1'b1);

        // All channels requesting: grants rotate 0,1,2,3,0.
        repeat (10) step(4'hF, 1'b1, 1'b0, 1'b0);
        repeat (5) step('0, 1'b1, 1'b1, 1'b0);
        step('0, 1'b1, 1'b0, 1'b0);

        // Channel 2 alone with a stalled bypass port.
        fix_fields = 1'b1;
        fix_desc = '{src: 64'h1000, dst: 64'h2000, len: 28'd64, ctl: 16'h0013};
        step(4'b0100, 1'b0, 1'b0, 1'b0);
        repeat (5) step('0, 1'b0, 1'b0, 1'b0);
        step('0, 1'b1, 1'b0, 1'b0);
        fix_fields = 1'b0;
        step('0, 1'b1, 1'b0, 1'b0);
        step('0, 1'b1, 1'b1, 1'b0);
        step('0, 1'b1, 1'b0, 1'b0);

        // Fill the tag FIFO, confirm the ninth request is held off until a completion.
        repeat (16) step(4'b0010, 1'b1, 1'b0, 1'b0);
        repeat (2) step(4'b0010, 1'b1, 1'b0, 1'b0);
        step(4'b0010, 1'b1, 1'b1, 1'b0);
        repeat (2) step(4'b0010, 1'b1, 1'b0, 1'b0);
        repeat (8) step('0, 1'b1, 1'b1, 1'b0);
        step('0, 1'b1, 1'b0, 1'b0);

        // Issue order 1,3,1 then three completions.
        repeat (2) step(4'b0010, 1'b1, 1'b0, 1'b0);
        repeat (2) step(4'b1000, 1'b1, 1'b0, 1'b0);
        repeat (2) step(4'b0010, 1'b1, 1'b0, 1'b0);
        repeat (3) begin
            step('0, 1'b1, 1'b1, 1'b0);
            step('0, 1'b1, 1'b0, 1'b0);
        end

        // Spurious completion, then reset mid-LOAD with three outstanding.
        step('0, 1'b1, 1'b1, 1'b0);
        repeat (2) step('0, 1'b1, 1'b0, 1'b0);
        repeat (6) step(4'hF, 1'b1, 1'b0, 1'b0);
        repeat (2) step(4'hF, 1'b0, 1'b0, 1'b0);
        repeat (2) step(4'hF, 1'b0, 1'b0, 1'b1);
        step('0, 1'b1, 1'b1, 1'b0);
        repeat (2) step('0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic, including occasional resets.
        for (int n = 0; n < 2000; n++) begin
            step(NUM_CH'($urandom), ($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 400) == 0);
        end
        step('0, 1'b0, 1'b0, 1'b0);

        @(negedge CLK);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
